// File: rtl/per_pkg.sv
// Shared types and defaults for the PERIFERICO port arbiter.
// Pure declarations: no latency, no backpressure.
package per_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      RELEASE,
      DONE,
      ABORT,
      FAIL
   } per_state_e;

   localparam int DATA_W_DEF      = 4;
   localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/per_arbiter_if.sv
// Requester and peripheral signals of the arbiter; master = arbiter side.
// Wires only: no latency; requests are level-held until done/err.
interface per_arbiter_if #(
   parameter int N_REQ  = 2,
   parameter int DATA_W = 4
) ();

   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_dados;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        done;
   logic [N_REQ-1:0]        err;
   logic                    busy;
   logic                    per_send;
   logic [DATA_W-1:0]       per_dados;
   logic                    per_ack;

   modport master (
      input  req, req_dados, per_ack,
      output gnt, done, err, busy, per_send, per_dados
   );

   modport slave (
      output req, req_dados, per_ack,
      input  gnt, done, err, busy, per_send, per_dados
   );

endinterface

// File: rtl/per_ack_sync.sv
// Multi-flop synchronizer for the asynchronous per_ack line.
// Latency STAGES cycles; no backpressure.
module per_ack_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/per_arbiter.sv
// Round-robin share of one 4-phase send/ack peripheral port; req to per_send 1 cycle.
// Requesters hold req until their done/err pulse; a stuck-high ack blocks new grants.
module per_arbiter
   import per_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int TIMEOUT     = 64
) (
   input  logic           per_clock,
   input  logic           per_reset,
   per_arbiter_if.master  bus
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   per_state_e        state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  pick;
   logic [TMR_W-1:0]  timer;
   logic [DATA_W-1:0] pick_dat;
   logic              ack_s;
   logic              timeout_hit;
   logic              timer_sat;

   // Descending scan so the requester closest to rr_ptr is the last to overwrite.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] w;
      int               j;
      w = ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N_REQ;
         if (r[j]) w = IDX_W'(j);
      end
      return w;
   endfunction

   per_ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (per_clock),
      .rst_n (per_reset),
      .d     (bus.per_ack),
      .q     (ack_s)
   );

   assign pick        = rr_pick(bus.req, rr_ptr);
   assign pick_dat    = bus.req_dados[int'(pick)*DATA_W +: DATA_W];
   assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT - 1));
   assign timer_sat   = (TIMEOUT == 0) || timeout_hit;
   assign bus.busy    = (state != IDLE);

   always_ff @(posedge per_clock or negedge per_reset) begin
      if (!per_reset) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         timer         <= '0;
         bus.gnt       <= '0;
         bus.done      <= '0;
         bus.err       <= '0;
         bus.per_send  <= 1'b0;
         bus.per_dados <= '0;
      end else begin
         case (state)
            IDLE: begin
               if ((|bus.req) && !ack_s) begin
                  bus.gnt       <= N_REQ'(1) << pick;
                  bus.per_dados <= pick_dat;
                  bus.per_send  <= 1'b1;
                  rr_ptr        <= IDX_W'((int'(pick) + 1) % N_REQ);
                  timer         <= '0;
                  state         <= SEND;
               end
            end
            SEND: begin
               if (ack_s) begin
                  bus.per_send <= 1'b0;
                  timer        <= '0;
                  state        <= RELEASE;
               end else if (timeout_hit) begin
                  bus.per_send <= 1'b0;
                  state        <= ABORT;
               end else if (!timer_sat) begin
                  timer <= timer + TMR_W'(1);
               end
            end
            RELEASE: begin
               if (!ack_s) begin
                  bus.done <= bus.gnt;
                  state    <= DONE;
               end else if (timeout_hit) begin
                  bus.err <= bus.gnt;
                  state   <= FAIL;
               end else if (!timer_sat) begin
                  timer <= timer + TMR_W'(1);
               end
            end
            // A late ack must be released before the error is reported.
            ABORT: begin
               if (!ack_s) begin
                  bus.err <= bus.gnt;
                  state   <= FAIL;
               end
            end
            DONE, FAIL: begin
               bus.done <= '0;
               bus.err  <= '0;
               bus.gnt  <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_per_arbiter.sv
// Scoreboard bench for per_arbiter: directed transactions push expectations,
// a negedge monitor pops and compares on every done/err pulse.
module tb_per_arbiter;

   localparam int N  = 2;
   localparam int DW = 4;
   localparam int TO = 8;

   typedef struct {
      logic [1:0] gnt;
      logic [3:0] dat;
      logic       is_err;
      int         send_len;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   per_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

   per_arbiter #(
      .N_REQ       (N),
      .DATA_W      (DW),
      .SYNC_STAGES (2),
      .TIMEOUT     (TO)
   ) dut (
      .per_clock (clk),
      .per_reset (rst_n),
      .bus       (bus)
   );

   exp_t       sb[$];
   exp_t       mon_e;
   int         total = 0;
   int         bad   = 0;
   int         peri_mode = 0;   // 0 normal, 1 never ack, 2 ack stuck high
   int         peri_cnt  = 0;
   int         mon_len   = 0;
   logic       mon_prev  = 1'b0;
   logic [3:0] mon_first = '0;
   logic [3:0] mon_last  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [1:0] g, input logic [3:0] d, input logic e, input int len);
      exp_t x;
      x.gnt      = g;
      x.dat      = d;
      x.is_err   = e;
      x.send_len = len;
      sb.push_back(x);
   endtask

   task automatic wait_pulse(input string name, input int max);
      int k;
      for (k = 0; k < max; k++) begin
         @(negedge clk);
         if ((|bus.done) || (|bus.err)) break;
      end
      if (k == max) begin
         total++;
         bad++;
         $display("FAIL %s: no done/err within %0d cycles", name, max);
      end
   endtask

   task automatic wait_send(input string name, input int max);
      int k;
      for (k = 0; k < max; k++) begin
         @(negedge clk);
         if (bus.per_send) break;
      end
      if (k == max) begin
         total++;
         bad++;
         $display("FAIL %s: per_send not raised within %0d cycles", name, max);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Peripheral: ack two cycles after seeing per_send, drop once per_send is gone.
   initial begin
      bus.per_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (peri_mode)
            1: bus.per_ack = 1'b0;
            2: bus.per_ack = 1'b1;
            default: begin
               if (bus.per_send) begin
                  peri_cnt++;
                  if (peri_cnt >= 2) bus.per_ack = 1'b1;
               end else begin
                  peri_cnt    = 0;
                  bus.per_ack = 1'b0;
               end
            end
         endcase
      end
   end

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_prev = 1'b0;
         end else begin
            if (bus.per_send) begin
               if (!mon_prev) begin
                  mon_len   = 0;
                  mon_first = bus.per_dados;
               end
               mon_len++;
               mon_last = bus.per_dados;
            end
            mon_prev = bus.per_send;
            if ((|bus.done) || (|bus.err)) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_pulse: done=%b err=%b gnt=%b", bus.done, bus.err, bus.gnt);
               end else begin
                  mon_e = sb.pop_front();
                  check("gnt_at_pulse", 32'(bus.gnt), 32'(mon_e.gnt));
                  check("done", 32'(bus.done), mon_e.is_err ? 32'h0 : 32'(mon_e.gnt));
                  check("err", 32'(bus.err), mon_e.is_err ? 32'(mon_e.gnt) : 32'h0);
                  check("per_dados_first", 32'(mon_first), 32'(mon_e.dat));
                  check("per_dados_last", 32'(mon_last), 32'(mon_e.dat));
                  if (mon_e.send_len != 0) check("send_len", 32'(mon_len), 32'(mon_e.send_len));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // Stimulus
   initial begin
      bus.req       = '0;
      bus.req_dados = '0;
      #12;
      check("rst_gnt", 32'(bus.gnt), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      check("rst_err", 32'(bus.err), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_per_send", 32'(bus.per_send), 32'h0);
      check("rst_per_dados", 32'(bus.per_dados), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single request
      bus.req_dados = 8'h0A;
      bus.req       = 2'b01;
      push_exp(2'b01, 4'hA, 1'b0, 0);
      wait_pulse("single", 40);
      bus.req = '0;
      @(negedge clk);
      check("single_busy_after", 32'(bus.busy), 32'h0);
      check("single_send_after", 32'(bus.per_send), 32'h0);

      // data changes after grant must not reach per_dados
      bus.req = 2'b01;
      push_exp(2'b01, 4'hA, 1'b0, 0);
      wait_send("hold_send", 20);
      bus.req_dados = 8'h0E;
      wait_pulse("hold", 40);
      bus.req = '0;

      // contention from a fresh rr_ptr
      pulse_reset();
      bus.req_dados = 8'hFE;
      push_exp(2'b01, 4'hE, 1'b0, 0);
      push_exp(2'b10, 4'hF, 1'b0, 0);
      push_exp(2'b01, 4'hE, 1'b0, 0);
      push_exp(2'b10, 4'hF, 1'b0, 0);
      bus.req = 2'b11;
      repeat (4) wait_pulse("contention", 40);
      bus.req = '0;

      // timeout with silent peripheral
      @(negedge clk);
      peri_mode     = 1;
      bus.req_dados = 8'h03;
      bus.req       = 2'b01;
      push_exp(2'b01, 4'h3, 1'b1, TO);
      wait_pulse("timeout", 40);
      bus.req   = '0;
      peri_mode = 0;
      @(negedge clk);
      bus.req_dados = 8'h50;
      bus.req       = 2'b10;
      push_exp(2'b10, 4'h5, 1'b0, 0);
      wait_pulse("after_timeout", 40);
      bus.req = '0;

      // ack stuck high blocks arbitration
      @(negedge clk);
      peri_mode = 2;
      repeat (4) @(negedge clk);
      bus.req_dados = 8'h0C;
      bus.req       = 2'b01;
      push_exp(2'b01, 4'hC, 1'b0, 0);
      repeat (3) begin
         @(negedge clk);
         check("stuck_no_gnt", 32'(bus.gnt), 32'h0);
         check("stuck_busy", 32'(bus.busy), 32'h0);
      end
      peri_mode = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stuck_release_gnt", 32'(bus.gnt), (k == 3) ? 32'h1 : 32'h0);
      end
      wait_pulse("stuck", 40);
      bus.req = '0;

      // asynchronous reset during SEND
      @(negedge clk);
      peri_mode     = 1;
      bus.req_dados = 8'h07;
      bus.req       = 2'b01;
      wait_send("midrst_send", 20);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_per_send", 32'(bus.per_send), 32'h0);
      check("midrst_gnt", 32'(bus.gnt), 32'h0);
      check("midrst_busy", 32'(bus.busy), 32'h0);
      bus.req       = 2'b10;
      bus.req_dados = 8'h60;
      peri_mode     = 0;
      push_exp(2'b10, 4'h6, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_first_gnt", 32'(bus.gnt), 32'h2);
      wait_pulse("midrst", 40);
      bus.req = '0;

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/per_arbiter.md
Name: per_arbiter

Overview:
- Shares one PERIFERICO 4-bit send/ack port between N requesters. Round-robin arbitration.
- Owns the full 4-phase handshake: raise per_send with data → wait per_ack=1 → drop per_send → wait per_ack=0.
- Sits between the CPU-side requesters and the peripheral. Reports completion or timeout back to the granted requester.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 4, width of the peripheral data bus.
- SYNC_STAGES, 2, flops on per_ack before use (≥2).
- TIMEOUT, 64, max cycles waiting in SEND or RELEASE; 0 disables timeout.

Ports:
- per_clock  in  1  system clock; all state on rising edge.
- per_reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester; held until done or err.
- req_dados  in  N_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
- gnt  out  N_REQ  one-hot; high for the whole granted transaction.
- done  out  N_REQ  1-cycle pulse to the granted requester on handshake completion.
- err  out  N_REQ  1-cycle pulse to the granted requester on timeout.
- busy  out  1  high whenever state ≠ IDLE.
- per_send  out  1  to PERIFERICO.
- per_dados  out  DATA_W  to PERIFERICO in_per_dados; stable while per_send=1.
- per_ack  in  1  from PERIFERICO; passes through the SYNC_STAGES synchronizer, giving ack_s.

Behaviour:
- Reset (per_reset=0, async):
  - state=IDLE; rr_ptr=0; timer=0; synchronizer flops=0.
  - gnt=0, done=0, err=0, busy=0, per_send=0, per_dados=0.
- IDLE:
  - Arbitrates only if any req=1 AND ack_s=0.
  - Winner = first requester with req=1, searching i = rr_ptr, rr_ptr+1, … mod N_REQ.
  - Next edge: gnt=onehot(winner); per_dados latched from req_dados[winner]; per_send=1; state=SEND; timer=0.
  - rr_ptr = (winner+1) mod N_REQ, updated at grant.
- SEND:
  - per_send=1; per_dados held at the latched value, ignoring later req_dados changes.
  - ack_s=1 → RELEASE, per_send=0, timer=0.
  - timer reaches TIMEOUT-1 with ack_s=0 → ABORT, per_send=0.
- RELEASE:
  - per_send=0.
  - ack_s=0 → DONE.
  - timer reaches TIMEOUT-1 → FAIL.
- DONE (1 cycle): done[winner]=1 → IDLE; gnt cleared on the same edge.
- ABORT:
  - per_send=0; waits ack_s=0, with no timeout.
  - If ack_s=1 appears here, the peripheral accepted late; still → FAIL once ack_s=0.
- FAIL (1 cycle): err[winner]=1 → IDLE; gnt cleared.
- Latency:
  - req to per_send = 1 cycle from IDLE.
  - Ideal transaction (peripheral acks in 1 cycle, ack sync 2 stages) ≈ 2 + 2·SYNC_STAGES + 1 cycles to done.
- Requests:
  - A req dropped after grant does not abort; the transaction completes and done/err still pulses.
  - A req dropped before grant is simply not served.
- Simultaneous requests are served strictly alternately under round-robin; no requester waits more than N_REQ-1 transactions.
- Back-to-back:
  - From DONE, the next grant can occur one cycle after the return to IDLE.
  - A requester holding req through its own done re-requests and competes normally.
- ack_s stuck high in IDLE: no grant is issued; busy=0.
- TIMEOUT=0: timer is ignored; SEND and RELEASE wait indefinitely.
- timer width = clog2(TIMEOUT+1); saturates and never wraps.
- Reset asserted mid-transaction: immediate return to reset values; per_send drops asynchronously.
- Invariants: gnt is one-hot or zero; done and err are never both set; per_send=1 only in SEND.

Decomposition:
- Package per_pkg:
  - state enum {IDLE, SEND, RELEASE, DONE, ABORT, FAIL}.
  - Constants DATA_W_DEF=4, SYNC_STAGES_DEF=2.
- Sub-module per_ack_sync: SYNC_STAGES-deep flop chain, async active-low reset to 0.
- Round-robin pick is a function inside per_arbiter, not a separate module.

Test Plan:
- Single request: req=01, req_dados[3:0]=4'b1010, peripheral acks 2 cycles after per_send → per_dados=1010 during SEND; per_send drops after ack_s; done=01 single pulse; busy returns to 0.
- Contention: req=11 continuously, data0=1110, data1=1111, per_arbiter reset to rr_ptr=0 → grants alternate 01, 10, 01, 10; per_dados alternates 1110/1111; done pulses alternate.
- Timeout: TIMEOUT=8, per_ack held 0 → per_send high exactly 8 cycles then 0; err=01 pulse; done never pulses; next req is granted normally.
- Ack stuck high: per_ack=1 before req → no gnt while per_ack=1; grant occurs SYNC_STAGES+1 cycles after per_ack falls.
- Reset mid-SEND: assert per_reset=0 while per_send=1 → per_send, gnt, busy go to 0 without waiting for a clock edge; after release, req=10 is granted first, since rr_ptr=0 and req0=0.
- Data change during SEND: req_dados[3:0] changes 1010→1110 after grant → per_dados stays 1010 until DONE.
